pzcorebus_memory_responder: RTL and testbench

- Slave-side pzcorebus endpoint for memory-profile buses: accepts commands and write data, then drives responses.
- Backed by a small internal word memory, so it acts as the responding end for bus masters in block-level benches and in minimal subsystems.
- Generates sresp bursts whose beat count and sresp_last encoding are exact for every read length and address offset.
- Handles one command at a time; no reordering.

---
 rtl/pzcorebus_memory_responder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_pzcorebus_memory_responder.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pzcorebus_memory_responder.sv
// ---------------------------------------------------------------------------
// pzcorebus_memory_responder
//
// Slave-side pzcorebus endpoint for memory-profile buses. It accepts one
// command at a time, takes the write data for WRITE / WRITE_NON_POSTED, and
// answers from a small internal word memory (DEPTH words of DATA_WIDTH bits).
//
// Handshake rule used on every channel: a transfer happens on a rising clock
// edge where valid and accept are both high. The slave keeps o_sresp_valid
// and the whole response payload stable until i_mresp_accept is seen.
//
// Command encoding (i_mcmd, 4 bits; bit 3 marks a non-posted command):
//   4'h0 NULL            4'h8 READ
//   4'h1 WRITE           4'h9 WRITE_NON_POSTED
//   4'h2 FULL_WRITE      4'hA FULL_WRITE_NON_POSTED
//   4'h3 BROADCAST       4'hB BROADCAST_NON_POSTED
//   4'h4 MESSAGE         4'hC MESSAGE_NON_POSTED
//   4'h5 ATOMIC          4'hD ATOMIC_NON_POSTED
// Response encoding (o_sresp, 2 bits): 2'b00 none, 2'b01 RESPONSE,
//   2'b10 RESPONSE_WITH_DATA.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_mcmd_valid / o_scmd_accept   command channel (i_mcmd, i_mid, i_maddr,
//                                  i_mlength; mlength==0 means MAX_LENGTH)
//   i_mdata_valid / o_sdata_accept write data channel (i_mdata,
//                                  i_mdata_byteen, i_mdata_last)
//   o_sresp_valid / i_mresp_accept response channel (o_sresp, o_sid,
//                                  o_serror, o_sdata, o_sresp_last)
//   o_debug_state                  current FSM state (IDLE=0, WRITE_DATA=1,
//                                  SINGLE_RESP=2, READ_RESP=3)
//
// Optional feature, macro PZCOREBUS_MEMORY_RESPONDER_RANGE_ERROR_EN:
//   commands whose word address is beyond DEPTH flag serror on every
//   response beat, read back zero data and have their writes discarded.
//   Without the macro the word address simply wraps modulo DEPTH.
// ---------------------------------------------------------------------------
module pzcorebus_memory_responder #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int ID_WIDTH        = 8,
    parameter int DATA_WIDTH      = 64,
    parameter int UNIT_DATA_WIDTH = 32,
    parameter int MAX_LENGTH      = 32,
    parameter int LENGTH_WIDTH    = 5,
    parameter int DEPTH           = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_mcmd_valid,
    output logic                      o_scmd_accept,
    input  logic [3:0]                i_mcmd,
    input  logic [ID_WIDTH-1:0]       i_mid,
    input  logic [ADDRESS_WIDTH-1:0]  i_maddr,
    input  logic [LENGTH_WIDTH-1:0]   i_mlength,
    input  logic                      i_mdata_valid,
    output logic                      o_sdata_accept,
    input  logic [DATA_WIDTH-1:0]     i_mdata,
    input  logic [DATA_WIDTH/8-1:0]   i_mdata_byteen,
    input  logic                      i_mdata_last,
    output logic                      o_sresp_valid,
    input  logic                      i_mresp_accept,
    output logic [1:0]                o_sresp,
    output logic [ID_WIDTH-1:0]       o_sid,
    output logic                      o_serror,
    output logic [DATA_WIDTH-1:0]     o_sdata,
    output logic [1:0]                o_sresp_last,
    output logic [1:0]                o_debug_state
);

    localparam int DATA_BYTE  = DATA_WIDTH / 8;
    localparam int UNIT_BYTE  = UNIT_DATA_WIDTH / 8;
    localparam int DATA_SIZE  = DATA_WIDTH / UNIT_DATA_WIDTH;
    localparam int DATA_OFF_W = $clog2(DATA_BYTE);
    localparam int UNIT_OFF_W = $clog2(UNIT_BYTE);
    localparam int SIZE_SHIFT = $clog2(DATA_SIZE);
    localparam int IDX_W      = $clog2(DEPTH);
    // Wide enough for MAX_LENGTH plus the largest unit offset.
    localparam int BURST_W    = LENGTH_WIDTH + 2;

    localparam logic [3:0] CMD_WRITE            = 4'h1;
    localparam logic [3:0] CMD_READ             = 4'h8;
    localparam logic [3:0] CMD_WRITE_NON_POSTED = 4'h9;

    localparam logic [1:0] RESP_NONE      = 2'b00;
    localparam logic [1:0] RESP_PLAIN     = 2'b01;
    localparam logic [1:0] RESP_WITH_DATA = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WRITE_DATA  = 2'd1,
        ST_SINGLE_RESP = 2'd2,
        ST_READ_RESP   = 2'd3
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    init_q;
    logic [3:0]              cmd_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [BURST_W-1:0]      burst_q;
    logic [BURST_W-1:0]      beat_cnt_q;   // beats already transferred
    logic [IDX_W-1:0]        idx_q;        // next word to write / to fetch
    logic                    err_q;
    logic                    range_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    cmd_fire;
    logic                    wbeat_fire;
    logic                    rbeat_fire;
    logic                    is_read;
    logic                    is_write;
    logic                    is_np;
    logic                    last_beat;
    logic                    mem_we;
    logic                    cmd_range_err;
    logic [IDX_W-1:0]        cmd_idx;
    logic [BURST_W-1:0]      cmd_len;
    logic [BURST_W-1:0]      cmd_offset;
    logic [BURST_W-1:0]      cmd_burst;

    // ---------------------------------------------------------------- decode
    assign is_read   = (i_mcmd == CMD_READ);
    assign is_write  = (i_mcmd == CMD_WRITE) || (i_mcmd == CMD_WRITE_NON_POSTED);
    assign is_np     = i_mcmd[3];
    assign cmd_idx   = i_maddr[DATA_OFF_W +: IDX_W];
    assign last_beat = ((beat_cnt_q + BURST_W'(1)) == burst_q);

    // Beats = ceil((len + unit offset inside the first word) / units per word).
    always_comb begin
        cmd_len    = (i_mlength == '0) ? BURST_W'(MAX_LENGTH) : BURST_W'(i_mlength);
        cmd_offset = BURST_W'(i_maddr[DATA_OFF_W-1:0] >> UNIT_OFF_W);
        cmd_burst  = (cmd_len + cmd_offset + BURST_W'(DATA_SIZE - 1)) >> SIZE_SHIFT;
    end

`ifdef PZCOREBUS_MEMORY_RESPONDER_RANGE_ERROR_EN
    assign cmd_range_err = |i_maddr[ADDRESS_WIDTH-1:DATA_OFF_W+IDX_W];
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_maddr[UNIT_OFF_W-1:0];
`else
    assign cmd_range_err = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_maddr[ADDRESS_WIDTH-1:DATA_OFF_W+IDX_W],
                                i_maddr[UNIT_OFF_W-1:0]};
`endif

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        o_scmd_accept  = 1'b0;
        o_sdata_accept = 1'b0;
        o_sresp_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // init_q keeps accept low while reset is (just) asserted.
                o_scmd_accept = init_q;
                if (i_mcmd_valid && init_q) begin
                    if (is_read) begin
                        state_d = ST_READ_RESP;
                    end else if (is_write) begin
                        state_d = ST_WRITE_DATA;
                    end else if (is_np) begin
                        state_d = ST_SINGLE_RESP;
                    end
                end
            end
            ST_WRITE_DATA: begin
                o_sdata_accept = 1'b1;
                if (i_mdata_valid && i_mdata_last) begin
                    state_d = (cmd_q == CMD_WRITE_NON_POSTED) ? ST_SINGLE_RESP : ST_IDLE;
                end
            end
            ST_SINGLE_RESP: begin
                o_sresp_valid = 1'b1;
                if (i_mresp_accept) begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ_RESP: begin
                o_sresp_valid = 1'b1;
                if (i_mresp_accept && last_beat) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_fire   = i_mcmd_valid && o_scmd_accept;
    assign wbeat_fire = i_mdata_valid && o_sdata_accept;
    assign rbeat_fire = (state_q == ST_READ_RESP) && i_mresp_accept;

    // -------------------------------------------------------------- datapath
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            init_q     <= 1'b0;
            cmd_q      <= '0;
            id_q       <= '0;
            burst_q    <= '0;
            beat_cnt_q <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            range_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            init_q <= 1'b1;
            if (cmd_fire) begin
                cmd_q      <= i_mcmd;
                id_q       <= i_mid;
                burst_q    <= cmd_burst;
                beat_cnt_q <= '0;
                err_q      <= is_np && !is_read && !is_write;
                range_q    <= cmd_range_err;
                if (is_read) begin
                    // First word is fetched now so the response can start next cycle.
                    idx_q   <= cmd_idx + IDX_W'(1);
                    rdata_q <= cmd_range_err ? '0 : mem_q[cmd_idx];
                end else begin
                    idx_q <= cmd_idx;
                end
            end
            if (wbeat_fire) begin
                idx_q <= idx_q + IDX_W'(1);
                // Saturate so an over-long write cannot alias back onto burst.
                if (beat_cnt_q != {BURST_W{1'b1}}) begin
                    beat_cnt_q <= beat_cnt_q + BURST_W'(1);
                end
                if (i_mdata_last && !last_beat) begin
                    err_q <= 1'b1;
                end
            end
            if (rbeat_fire && !last_beat) begin
                idx_q      <= idx_q + IDX_W'(1);
                beat_cnt_q <= beat_cnt_q + BURST_W'(1);
                rdata_q    <= range_q ? '0 : mem_q[idx_q];
            end
        end
    end

    // Memory has no reset; beats beyond the burst are accepted but dropped.
    assign mem_we = wbeat_fire && (beat_cnt_q < burst_q) && !range_q;

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < DATA_BYTE; b++) begin
                if (i_mdata_byteen[b]) begin
                    mem_q[idx_q][b*8 +: 8] <= i_mdata[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------ response payload
    assign o_sresp       = (state_q == ST_READ_RESP)   ? RESP_WITH_DATA :
                           (state_q == ST_SINGLE_RESP) ? RESP_PLAIN : RESP_NONE;
    assign o_sid         = o_sresp_valid ? id_q : '0;
    assign o_serror      = o_sresp_valid && (err_q || range_q);
    assign o_sdata       = (state_q == ST_READ_RESP) ? rdata_q : '0;
    assign o_sresp_last  = {1'b0, (state_q == ST_SINGLE_RESP) ||
                                  ((state_q == ST_READ_RESP) && last_beat)};
    assign o_debug_state = state_q;

endmodule

// File: tb/tb_pzcorebus_memory_responder.sv
module tb_pzcorebus_memory_responder;

    localparam int AW    = 32;
    localparam int IW    = 8;
    localparam int DW    = 64;
    localparam int LW    = 5;
    localparam int DEPTH = 64;
    localparam int EW    = 2 + IW + 1 + DW + 2;

    localparam logic [3:0] CMD_WRITE   = 4'h1;
    localparam logic [3:0] CMD_MSG     = 4'h4;
    localparam logic [3:0] CMD_READ    = 4'h8;
    localparam logic [3:0] CMD_WNP     = 4'h9;
    localparam logic [3:0] CMD_MSG_NP  = 4'hC;
    localparam logic [1:0] RESP        = 2'b01;
    localparam logic [1:0] RESP_DATA   = 2'b10;

    // ------------------------------------------------------ clock and reset
    logic            clk;
    logic            rst_n;
    logic            mcmd_valid;
    logic            o_scmd_accept;
    logic [3:0]      mcmd;
    logic [IW-1:0]   mid;
    logic [AW-1:0]   maddr;
    logic [LW-1:0]   mlength;
    logic            mdata_valid;
    logic            o_sdata_accept;
    logic [DW-1:0]   mdata;
    logic [DW/8-1:0] mdata_byteen;
    logic            mdata_last;
    logic            o_sresp_valid;
    logic            mresp_accept;
    logic [1:0]      o_sresp;
    logic [IW-1:0]   o_sid;
    logic            o_serror;
    logic [DW-1:0]   o_sdata;
    logic [1:0]      o_sresp_last;
    logic [1:0]      o_debug_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pzcorebus_memory_responder dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_mcmd_valid   (mcmd_valid),
        .o_scmd_accept  (o_scmd_accept),
        .i_mcmd         (mcmd),
        .i_mid          (mid),
        .i_maddr        (maddr),
        .i_mlength      (mlength),
        .i_mdata_valid  (mdata_valid),
        .o_sdata_accept (o_sdata_accept),
        .i_mdata        (mdata),
        .i_mdata_byteen (mdata_byteen),
        .i_mdata_last   (mdata_last),
        .o_sresp_valid  (o_sresp_valid),
        .i_mresp_accept (mresp_accept),
        .o_sresp        (o_sresp),
        .o_sid          (o_sid),
        .o_serror       (o_serror),
        .o_sdata        (o_sdata),
        .o_sresp_last   (o_sresp_last),
        .o_debug_state  (o_debug_state)
    );

    // ------------------------------------------------------------ scoreboard
    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];     // expected response beats, in order
    logic [EW-1:0] seen_q[$];    // accepted response beats, in order
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] wbuf [16];
    logic [7:0]    wbe [16];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    function automatic logic [EW-1:0] pack(input logic [1:0] r, input logic [IW-1:0] id,
                                           input logic e, input logic [DW-1:0] d,
                                           input logic [1:0] l);
        return {r, id, e, d, l};
    endfunction

    function automatic logic [DW-1:0] seen_data(input int i);
        logic [EW-1:0] p;
        p = seen_q[i];
        return p[DW+1:2];
    endfunction

    function automatic logic [1:0] seen_last(input int i);
        logic [EW-1:0] p;
        p = seen_q[i];
        return p[1:0];
    endfunction

    function automatic logic seen_err(input int i);
        logic [EW-1:0] p;
        p = seen_q[i];
        return p[DW+2];
    endfunction

    function automatic logic [IW-1:0] seen_id(input int i);
        logic [EW-1:0] p;
        p = seen_q[i];
        return p[DW+3 +: IW];
    endfunction

    // Beats a transfer occupies: units plus starting unit offset, 2 units per word.
    function automatic int burst_of(input logic [AW-1:0] a, input logic [LW-1:0] l);
        int len;
        int off;
        len = (l == 0) ? 32 : int'(l);
        off = int'(a % 8) / 4;
        return (len + off + 1) / 2;
    endfunction

    function automatic int word_of(input logic [AW-1:0] a);
        return int'((a / 8) % DEPTH);
    endfunction

    // Compare process: every cycle a response is presented it must match the
    // head of the expected queue; the head retires when the master accepts.
    always @(negedge clk) begin
        if (rst_n && o_sresp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=%0h required=none",
                         pack(o_sresp, o_sid, o_serror, o_sdata, o_sresp_last));
            end else begin
                check("resp_beat", pack(o_sresp, o_sid, o_serror, o_sdata, o_sresp_last), exp_q[0]);
                if (mresp_accept) begin
                    void'(exp_q.pop_front());
                    seen_q.push_back(pack(o_sresp, o_sid, o_serror, o_sdata, o_sresp_last));
                end
            end
        end
    end

    // ---------------------------------------------------------- driver tasks
    task automatic send_cmd(input logic [3:0] c, input logic [IW-1:0] id,
                            input logic [AW-1:0] a, input logic [LW-1:0] l);
        bit done;
        done = 0;
        mcmd_valid = 1'b1;
        mcmd = c;
        mid = id;
        maddr = a;
        mlength = l;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = o_scmd_accept;
            @(posedge clk);
            #1;
        end
        mcmd_valid = 1'b0;
        if (!done) timeout_fail("scmd_accept");
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [7:0] be, input logic last);
        bit done;
        done = 0;
        mdata_valid = 1'b1;
        mdata = d;
        mdata_byteen = be;
        mdata_last = last;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = o_sdata_accept;
            @(posedge clk);
            #1;
        end
        mdata_valid = 1'b0;
        mdata_last = 1'b0;
        if (!done) timeout_fail("sdata_accept");
    endtask

    // Waits until every expected beat has been accepted, then the slave must
    // be back to accepting commands in the very next cycle.
    task automatic drain(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = (exp_q.size() == 0);
        end
        if (!ok) timeout_fail({name, "_drain"});
        check({name, "_cmd_accept_back"}, o_scmd_accept, 1'b1);
    endtask

    task automatic push_read(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int n;
        int w;
        n = burst_of(a, l);
        w = word_of(a);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pack(RESP_DATA, id, 1'b0, model_mem[(w + i) % DEPTH],
                                 (i == n - 1) ? 2'b01 : 2'b00));
        end
    endtask

    task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [LW-1:0] l);
        push_read(id, a, l);
        send_cmd(CMD_READ, id, a, l);
        check("read_first_beat_latency", o_sresp_valid, 1'b1);
        drain("read");
    endtask

    // Writes nbeats beats from wbuf/wbe; last flag on the final beat sent.
    task automatic do_write(input logic [3:0] c, input logic [IW-1:0] id, input logic [AW-1:0] a,
                            input logic [LW-1:0] l, input int nbeats);
        int n;
        int w;
        n = burst_of(a, l);
        w = word_of(a);
        for (int i = 0; i < nbeats && i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                if (wbe[i][b]) model_mem[(w + i) % DEPTH][b*8 +: 8] = wbuf[i][b*8 +: 8];
            end
        end
        if (c == CMD_WNP) exp_q.push_back(pack(RESP, id, (nbeats != n), '0, 2'b01));
        send_cmd(c, id, a, l);
        for (int i = 0; i < nbeats; i++) send_beat(wbuf[i], wbe[i], (i == nbeats - 1));
        if (c == CMD_WNP) drain("write_np");
        else check("posted_write_cmd_accept_back", o_scmd_accept, 1'b1);
    endtask

    // ---------------------------------------------------------------- tests
    localparam logic [DW-1:0] DATA_A = 64'hAAAA_0001_AAAA_0002;
    localparam logic [DW-1:0] DATA_B = 64'hBBBB_0003_BBBB_0004;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        logic [DW-1:0] held_data;
        logic [1:0]    held_last;
        bit ok;

        rst_n = 1'b0;
        mcmd_valid = 1'b0;
        mcmd = '0;
        mid = '0;
        maddr = '0;
        mlength = '0;
        mdata_valid = 1'b0;
        mdata = '0;
        mdata_byteen = '0;
        mdata_last = 1'b0;
        mresp_accept = 1'b1;
        #1;
        check("reset_outputs", {o_scmd_accept, o_sdata_accept, o_sresp_valid, o_sresp, o_sid,
                                o_serror, o_sdata, o_sresp_last}, '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Write data offered with no command must wait.
        mdata_valid = 1'b1;
        @(negedge clk);
        check("idle_sdata_accept_low", o_sdata_accept, 1'b0);
        @(negedge clk);
        check("idle_sdata_accept_low2", o_sdata_accept, 1'b0);
        @(posedge clk);
        #1;
        mdata_valid = 1'b0;

        // Fill words 0..15 with a posted 16-beat write (mlength 0 = 32 units).
        for (int i = 0; i < 16; i++) begin
            wbuf[i] = {32'hC0DE_0000 + 32'(i), 32'(i)};
            wbe[i]  = 8'hFF;
        end
        do_write(CMD_WRITE, 8'h01, 32'h0, 5'd0, 16);

        // Non-posted write of A,B to words 0,1.
        wbuf[0] = DATA_A;
        wbuf[1] = DATA_B;
        base = seen_q.size();
        do_write(CMD_WNP, 8'h11, 32'h0, 5'd4, 2);
        check("wnp_beats", seen_q.size() - base, 1);
        check("wnp_sid", seen_id(base), 8'h11);
        check("wnp_serror", seen_err(base), 1'b0);
        check("wnp_last", seen_last(base), 2'b01);

        // Read back A,B.
        base = seen_q.size();
        do_read(8'h22, 32'h0, 5'd4);
        check("read4_beats", seen_q.size() - base, 2);
        check("read4_data0", seen_data(base), DATA_A);
        check("read4_data1", seen_data(base + 1), DATA_B);
        check("read4_last0", seen_last(base), 2'b00);
        check("read4_last1", seen_last(base + 1), 2'b01);

        // Offset start: 2 units from unit 1 spans two words; 1 unit fits in one.
        base = seen_q.size();
        do_read(8'h23, 32'h4, 5'd2);
        check("read_off_len2_beats", seen_q.size() - base, 2);
        base = seen_q.size();
        do_read(8'h24, 32'h4, 5'd1);
        check("read_off_len1_beats", seen_q.size() - base, 1);
        check("read_off_len1_data", seen_data(base), DATA_A);

        // Byte-enabled partial write of word 2, low four bytes only.
        wbuf[0] = 64'h1234_5678_9ABC_DEF0;
        wbe[0]  = 8'h0F;
        do_write(CMD_WRITE, 8'h30, 32'h10, 5'd2, 1);
        base = seen_q.size();
        do_read(8'h31, 32'h10, 5'd2);
        check("byteen_merge", seen_data(base), 64'hC0DE_0002_9ABC_DEF0);

        // Max-length read with a 3-cycle response stall mid-burst.
        base = seen_q.size();
        push_read(8'h40, 32'h0, 5'd0);
        send_cmd(CMD_READ, 8'h40, 32'h0, 5'd0);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = (seen_q.size() >= base + 4);
            if (!ok) begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) timeout_fail("stall_reach_beat5");
        mresp_accept = 1'b0;
        @(negedge clk);
        held_data = o_sdata;
        held_last = o_sresp_last;
        check("stall_beat5_data", held_data, 64'hC0DE_0004_0000_0004);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stall_valid", o_sresp_valid, 1'b1);
            check("stall_data_stable", o_sdata, held_data);
            check("stall_last_stable", o_sresp_last, held_last);
        end
        @(posedge clk);
        #1;
        mresp_accept = 1'b1;
        drain("max_read");
        check("max_read_beats", seen_q.size() - base, 16);

        // Length error: 4 units need 2 beats, last arrives on beat 1.
        wbuf[0] = 64'hEEEE_0005_EEEE_0006;
        wbe[0]  = 8'hFF;
        base = seen_q.size();
        do_write(CMD_WNP, 8'h50, 32'h0, 5'd4, 1);
        check("len_err_serror", seen_err(base), 1'b1);
        base = seen_q.size();
        do_read(8'h51, 32'h0, 5'd4);
        check("after_err_data0", seen_data(base), 64'hEEEE_0005_EEEE_0006);
        check("after_err_data1", seen_data(base + 1), DATA_B);

        // Unsupported non-posted command answers with an error; posted one is dropped.
        base = seen_q.size();
        exp_q.push_back(pack(RESP, 8'h60, 1'b1, '0, 2'b01));
        send_cmd(CMD_MSG_NP, 8'h60, 32'h0, 5'd1);
        drain("unsupported_np");
        check("unsupported_np_serror", seen_err(base), 1'b1);
        send_cmd(CMD_MSG, 8'h61, 32'h0, 5'd1);
        check("posted_dropped_accept", o_scmd_accept, 1'b1);

        // Word index wraps from the last word back to word 0.
        wbuf[0] = 64'h7777_0063_7777_0063;
        wbuf[1] = 64'h8888_0000_8888_0000;
        wbe[0]  = 8'hFF;
        wbe[1]  = 8'hFF;
        do_write(CMD_WNP, 8'h70, 32'h1F8, 5'd4, 2);
        base = seen_q.size();
        do_read(8'h71, 32'h1F8, 5'd4);
        check("wrap_data0", seen_data(base), 64'h7777_0063_7777_0063);
        check("wrap_data1", seen_data(base + 1), 64'h8888_0000_8888_0000);

        // Reset while beat 3 of a 16-beat read is on the bus.
        base = seen_q.size();
        push_read(8'h80, 32'h0, 5'd0);
        send_cmd(CMD_READ, 8'h80, 32'h0, 5'd0);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = (seen_q.size() >= base + 2);
            if (!ok) begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) timeout_fail("reset_reach_beat3");
        rst_n = 1'b0;
        #1;
        check("reset_mid_burst_valid", o_sresp_valid, 1'b0);
        check("reset_mid_burst_accept", o_scmd_accept, 1'b0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        base = seen_q.size();
        do_read(8'h81, 32'h0, 5'd0);
        check("post_reset_beats", seen_q.size() - base, 16);
        check("post_reset_data0", seen_data(base), 64'h8888_0000_8888_0000);
        check("post_reset_last", seen_last(base + 15), 2'b01);

        repeat (2) @(posedge clk);
        #1;
        check("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
